// File: rtl/sad_pkg.sv
// sad_pkg: shared types and default sizes for the SAD best-match search.
//   sad_best_state_t : search controller FSM state encoding
//   SAD_W_DEF        : default SAD result width (matches sad core dt_o)
//   NUM_CAND_DEF     : default number of candidate blocks per search
package sad_pkg;

  localparam int SAD_W_DEF    = 32;
  localparam int NUM_CAND_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_CMP,
    S_HOLD
  } sad_best_state_t;

endpackage

// File: rtl/sad_best_reg.sv
// sad_best_reg: result capture and running-minimum register for the search.
// Optional feature macro: SAD_BEST_EARLY_EXIT_EN (drives zero_exit_o).
// Ports:
//   clk          clock
//   rst_i        synchronous active-high reset
//   clr_i        new search: arms unconditional load of the first result
//   cap_i        capture sad core result dt_i into cur_q
//   cmp_en_i     compare cur_q against best and update on strict less
//   dt_i         sad core result
//   idx_i        candidate index of the captured result
//   best_sad_o   running minimum SAD
//   best_idx_o   index of the running minimum
//   zero_exit_o  captured result is zero and early exit is enabled
module sad_best_reg #(
  parameter int SAD_W = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             cap_i,
  input  logic             cmp_en_i,
  input  logic [SAD_W-1:0] dt_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic             zero_exit_o
);

  logic [SAD_W-1:0] cur_q;
  logic [SAD_W-1:0] best_sad_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             first_q;
  logic             upd_d;

  // Strict less keeps the lower index on ties; first result always loads.
  assign upd_d = cmp_en_i && (first_q || (cur_q < best_sad_q));

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cur_q      <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      first_q    <= 1'b0;
    end else begin
      if (clr_i)    first_q <= 1'b1;
      if (cap_i)    cur_q   <= dt_i;
      if (cmp_en_i) first_q <= 1'b0;
      if (upd_d) begin
        best_sad_q <= cur_q;
        best_idx_q <= idx_i;
      end
    end
  end

  assign best_sad_o = best_sad_q;
  assign best_idx_o = best_idx_q;

`ifdef SAD_BEST_EARLY_EXIT_EN
  assign zero_exit_o = (cur_q == '0);
`else
  assign zero_exit_o = 1'b0;
`endif

endmodule

// File: rtl/sad_best_match.sv
// sad_best_match: drives the sad core once per candidate block, tracks the
// minimum SAD and its index, and hands the result off over valid/ready.
// Optional feature macro: SAD_BEST_EARLY_EXIT_EN (stop at the first zero SAD).
// Ports:
//   clk         clock
//   rst_i       synchronous active-high reset
//   start_i     begin a new search (accepted only when idle)
//   sad_enb_o   one-cycle launch pulse to the sad core
//   sad_busy_i  sad core busy
//   sad_dt_i    sad core result
//   cand_idx_o  candidate under evaluation (also steers the address generator)
//   busy_o      search in progress, until the result is accepted
//   best_sad_o  minimum SAD of the search
//   best_idx_o  index of the minimum
//   valid_o     result valid
//   ready_i     consumer accepts result
module sad_best_match
  import sad_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int SAD_W    = SAD_W_DEF,
  localparam int IDX_W   = $clog2(NUM_CAND)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             sad_enb_o,
  input  logic             sad_busy_i,
  input  logic [SAD_W-1:0] sad_dt_i,
  output logic [IDX_W-1:0] cand_idx_o,
  output logic             busy_o,
  output logic [SAD_W-1:0] best_sad_o,
  output logic [IDX_W-1:0] best_idx_o,
  output logic             valid_o,
  input  logic             ready_i
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  sad_best_state_t  state_q;
  logic             sad_enb_q;
  logic             busy_q;
  logic             valid_q;
  logic [IDX_W-1:0] cand_q;

  logic clr_d;
  logic cap_d;
  logic cmp_en_d;
  logic zero_exit;

  assign clr_d    = (state_q == S_IDLE) && start_i;
  assign cap_d    = (state_q == S_WAIT_DONE) && !sad_busy_i;
  assign cmp_en_d = (state_q == S_CMP);

  sad_best_reg #(
    .SAD_W (SAD_W),
    .IDX_W (IDX_W)
  ) u_best (
    .clk         (clk),
    .rst_i       (rst_i),
    .clr_i       (clr_d),
    .cap_i       (cap_d),
    .cmp_en_i    (cmp_en_d),
    .dt_i        (sad_dt_i),
    .idx_i       (cand_q),
    .best_sad_o  (best_sad_o),
    .best_idx_o  (best_idx_o),
    .zero_exit_o (zero_exit)
  );

  // Outputs are registered: sad_enb_q is set on the edge entering LAUNCH so
  // it is high for exactly the LAUNCH cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      sad_enb_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      cand_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cand_q    <= '0;
            busy_q    <= 1'b1;
            sad_enb_q <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          sad_enb_q <= 1'b0;
          state_q   <= S_WAIT_BUSY;
        end
        // Wait for busy to rise first so a stale low busy is not taken as done.
        S_WAIT_BUSY: begin
          if (sad_busy_i) state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!sad_busy_i) state_q <= S_CMP;
        end
        S_CMP: begin
          if (zero_exit || (cand_q == LAST_IDX)) begin
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            cand_q    <= cand_q + IDX_W'(1);
            sad_enb_q <= 1'b1;
            state_q   <= S_LAUNCH;
          end
        end
        S_HOLD: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sad_enb_o  = sad_enb_q;
  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign cand_idx_o = cand_q;

endmodule

// File: tb/tb_sad_best_match.sv
module tb_sad_best_match;

  localparam int NC = 4;
  localparam int SW = 32;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          sad_enb_o;
  logic          sad_busy_i = 1'b0;
  logic [SW-1:0] sad_dt_i = '0;
  logic [IW-1:0] cand_idx_o;
  logic          busy_o;
  logic [SW-1:0] best_sad_o;
  logic [IW-1:0] best_idx_o;
  logic          valid_o;
  logic          ready_i = 1'b0;

  always #5 clk = ~clk;

  sad_best_match #(.NUM_CAND(NC), .SAD_W(SW)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .sad_enb_o  (sad_enb_o),
    .sad_busy_i (sad_busy_i),
    .sad_dt_i   (sad_dt_i),
    .cand_idx_o (cand_idx_o),
    .busy_o     (busy_o),
    .best_sad_o (best_sad_o),
    .best_idx_o (best_idx_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // sad core stub: busy rises one cycle after enb, stays high 4 cycles,
  // result for the launched candidate appears as busy falls.
  logic [SW-1:0] sads [NC];
  logic          pend = 1'b0;
  int            cnt = 0;
  logic [IW-1:0] stub_idx = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      pend       <= 1'b0;
      sad_busy_i <= 1'b0;
      cnt        <= 0;
    end else begin
      pend <= sad_enb_o;
      if (sad_enb_o) stub_idx <= cand_idx_o;
      if (pend) begin
        sad_busy_i <= 1'b1;
        cnt        <= 4;
      end else if (sad_busy_i) begin
        if (cnt == 1) begin
          sad_busy_i <= 1'b0;
          sad_dt_i   <= sads[stub_idx];
        end
        cnt <= cnt - 1;
      end
    end
  end

  // Launch and valid-pulse monitors.
  int   launch_q[$];
  int   vrise = 0;
  logic vprev = 1'b0;
  always @(negedge clk) begin
    if (!rst_i && sad_enb_o) launch_q.push_back(int'(cand_idx_o));
    if (valid_o && !vprev) vrise++;
    vprev = valid_o;
  end

  // Reference: minimum over candidates, first (lowest) index wins ties;
  // with early exit the search stops at the first zero.
  task automatic ref_model(input logic [SW-1:0] v [NC], output logic [SW-1:0] b,
                           output int bi, output int nl);
    b  = v[0];
    bi = 0;
    nl = NC;
    for (int i = 0; i < NC; i++) begin
      if (i == 0 || v[i] < b) begin
        b  = v[i];
        bi = i;
      end
`ifdef SAD_BEST_EARLY_EXIT_EN
      if (v[i] == 0) begin
        nl = i + 1;
        break;
      end
`endif
    end
  endtask

  task automatic run_search(input string tag, input logic [SW-1:0] v [NC], input int hold);
    logic [SW-1:0] eb;
    int            ei, en;
    int            t;
    logic          stable;
    ref_model(v, eb, ei, en);
    sads = v;
    launch_q.delete();
    vrise = 0;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check_val({tag, "_busy_on"}, busy_o, 1);
    t = 0;
    while (!valid_o && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!valid_o) begin
      check_val({tag, "_valid_timeout"}, 0, 1);
      return;
    end
    check_val({tag, "_best_sad"}, best_sad_o, eb);
    check_val({tag, "_best_idx"}, best_idx_o, ei);
    check_val({tag, "_launches"}, launch_q.size(), en);
    for (int i = 0; i < launch_q.size() && i < en; i++)
      check_val($sformatf("%s_launch_idx%0d", tag, i), launch_q[i], i);
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      start_i = (i == 3);
      @(negedge clk);
      if (!valid_o || best_sad_o !== eb || best_idx_o !== IW'(ei) || !busy_o) stable = 1'b0;
    end
    start_i = 1'b0;
    if (hold > 0) check_val({tag, "_hold_stable"}, stable, 1);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check_val({tag, "_valid_off"}, valid_o, 0);
    check_val({tag, "_busy_off"}, busy_o, 0);
    check_val({tag, "_valid_pulses"}, vrise, 1);
    repeat (3) @(negedge clk);
    check_val({tag, "_no_extra_launch"}, launch_q.size(), en);
  endtask

  logic [SW-1:0] v [NC];
  int            t;
  int            nl_snap;

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_enb", sad_enb_o, 0);
    check_val("rst_valid", valid_o, 0);
    check_val("rst_cand", cand_idx_o, 0);
    check_val("rst_best_sad", best_sad_o, 0);
    check_val("rst_best_idx", best_idx_o, 0);
    rst_i = 1'b0;

    v = '{100, 50, 75, 60};
    run_search("basic", v, 0);
    v = '{30, 30, 40, 30};
    run_search("tie", v, 0);
    v = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_search("allones", v, 0);
    v = '{9, 4, 7, 8};
    run_search("hold", v, 10);
    v = '{12, 3, 3, 1};
    run_search("restart", v, 0);

    // Reset during WAIT_DONE of candidate 2.
    sads = '{1, 2, 3, 4};
    launch_q.delete();
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    t = 0;
    while (!(sad_busy_i && cand_idx_o == 2) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("midrst_reached_cand2", cand_idx_o, 2);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    check_val("midrst_busy", busy_o, 0);
    check_val("midrst_enb", sad_enb_o, 0);
    check_val("midrst_valid", valid_o, 0);
    check_val("midrst_cand", cand_idx_o, 0);
    check_val("midrst_best_sad", best_sad_o, 0);
    rst_i = 1'b0;
    nl_snap = launch_q.size();
    repeat (30) @(negedge clk);
    check_val("midrst_no_launch", launch_q.size(), nl_snap);
    check_val("midrst_idle_busy", busy_o, 0);

    v = '{9, 0, 5, 7};
    run_search("zero", v, 0);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NC; i++)
        v[i] = (r < 4) ? SW'($urandom_range(0, 5)) : SW'($urandom);
      run_search($sformatf("rnd%0d", r), v, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
